// File: rtl/uart2apb_pkg.sv
// Shared constants and types for the uart2apb command parser.
//   CMD_WR / CMD_RD : frame command bytes
//   state_e         : parser state encoding
package uart2apb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] CMD_WR = 8'hA1;
  localparam logic [BYTE_W-1:0] CMD_RD = 8'hA0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } state_e;

endpackage

// File: rtl/uart2apb_cmd_parser_if.sv
// Handshake bundle between the prefetch FIFO, the command parser and the APB master.
//   data_in_valid/data_in/data_in_ready : byte stream from the prefetch FIFO
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : assembled APB request
//   frame_err/timeout_err : single-cycle error pulses
// slave  : parser view (consumes bytes, produces commands)
// master : environment view (FIFO + APB master)
interface uart2apb_cmd_parser_if;
  import uart2apb_pkg::*;

  logic              data_in_valid;
  logic [BYTE_W-1:0] data_in;
  logic              data_in_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [WORD_W-1:0] cmd_addr;
  logic [WORD_W-1:0] cmd_wdata;
  logic              frame_err;
  logic              timeout_err;

  modport slave (
    input  data_in_valid, data_in, cmd_ready,
    output data_in_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
           frame_err, timeout_err
  );

  modport master (
    output data_in_valid, data_in, cmd_ready,
    input  data_in_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
           frame_err, timeout_err
  );

endinterface

// File: rtl/uart2apb_cmd_parser.sv
// Assembles CMD + 4 address bytes (+ 4 write-data bytes) into one APB request.
// Ports: clk, rst_n (async active-low), bus (slave modport of uart2apb_cmd_parser_if).
// TIMEOUT idle cycles between bytes of a frame abort it; TIMEOUT = 0 disables this.
module uart2apb_cmd_parser
  import uart2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart2apb_cmd_parser_if.slave        bus
);

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              data_in_ready_q, data_in_ready_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [WORD_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [WORD_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic accept_c, last_byte_c, expire_c, cmd_byte_c;

  // An accepted byte always beats a simultaneous counter expiry.
  assign accept_c    = bus.data_in_valid & data_in_ready_q;
  assign last_byte_c = accept_c && (bcnt_q == 2'd3);
  assign cmd_byte_c  = (bus.data_in == CMD_WR) || (bus.data_in == CMD_RD);
  assign expire_c    = TO_EN && ((state_q == ADDR) || (state_q == DATA)) &&
                       !accept_c && (to_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_c && cmd_byte_c) state_d = ADDR;
      ADDR:  if (last_byte_c)   state_d = cmd_write_q ? DATA : ISSUE;
             else if (expire_c) state_d = IDLE;
      DATA:  if (last_byte_c)   state_d = ISSUE;
             else if (expire_c) state_d = IDLE;
      ISSUE: if (bus.cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    bcnt_d          = bcnt_q;
    to_cnt_d        = '0;
    cmd_write_d     = cmd_write_q;
    cmd_addr_d      = cmd_addr_q;
    cmd_wdata_d     = cmd_wdata_q;
    frame_err_d     = 1'b0;
    timeout_err_d   = 1'b0;
    data_in_ready_d = (state_d != ISSUE);
    cmd_valid_d     = (state_d == ISSUE);
    case (state_q)
      IDLE: begin
        bcnt_d = 2'd0;
        if (accept_c) begin
          if (cmd_byte_c) begin
            cmd_write_d = (bus.data_in == CMD_WR);
            cmd_wdata_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ADDR, DATA: begin
        if (accept_c) begin
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == ADDR) cmd_addr_d  = {cmd_addr_q[WORD_W-BYTE_W-1:0], bus.data_in};
          else                 cmd_wdata_d = {cmd_wdata_q[WORD_W-BYTE_W-1:0], bus.data_in};
        end else if (expire_c) begin
          bcnt_d        = 2'd0;
          timeout_err_d = 1'b1;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: bcnt_d = 2'd0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q          <= 2'd0;
      to_cnt_q        <= '0;
      data_in_ready_q <= 1'b1;
      cmd_valid_q     <= 1'b0;
      cmd_write_q     <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_wdata_q     <= '0;
      frame_err_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      bcnt_q          <= bcnt_d;
      to_cnt_q        <= to_cnt_d;
      data_in_ready_q <= data_in_ready_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_write_q     <= cmd_write_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_wdata_q     <= cmd_wdata_d;
      frame_err_q     <= frame_err_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.data_in_ready = data_in_ready_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_write     = cmd_write_q;
  assign bus.cmd_addr      = cmd_addr_q;
  assign bus.cmd_wdata     = cmd_wdata_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart2apb_cmd_parser.sv
// Directed bench for uart2apb_cmd_parser with TIMEOUT = 16.
module tb_uart2apb_cmd_parser;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   ferr_cnt = 0;
  int   terr_cnt = 0;
  int   both_cnt = 0;

  uart2apb_cmd_parser_if bus ();

  uart2apb_cmd_parser #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Error pulse bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1)   ferr_cnt++;
    if (bus.timeout_err === 1'b1) terr_cnt++;
    if (bus.frame_err === 1'b1 && bus.timeout_err === 1'b1) both_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte; returns in the cycle after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.data_in_valid = 1'b1;
    bus.data_in       = b;
    while (bus.data_in_ready !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $error("FAIL send_wait observed=ready_low expected=ready_high");
    end
    tick(1);
    bus.data_in_valid = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.data_in       = 8'h00;
    bus.cmd_ready     = 1'b1;
    tick(3);

    // Reset values
    chk("rst_ready", 32'(bus.data_in_ready), 32'd1);
    chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_write", 32'(bus.cmd_write), 32'd0);
    chk("rst_addr", bus.cmd_addr, 32'h0);
    chk("rst_wdata", bus.cmd_wdata, 32'h0);
    chk("rst_errs", {30'd0, bus.frame_err, bus.timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Read frame, cmd_ready high: one cycle of cmd_valid right after last byte
    send_byte(8'hA0); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    chk("rd_not_yet", 32'(bus.cmd_valid), 32'd0);
    send_byte(8'h78);
    chk("rd_valid", 32'(bus.cmd_valid), 32'd1);
    chk("rd_write", 32'(bus.cmd_write), 32'd0);
    chk("rd_addr", bus.cmd_addr, 32'h12345678);
    chk("rd_wdata", bus.cmd_wdata, 32'h0);
    chk("rd_ready_low", 32'(bus.data_in_ready), 32'd0);
    tick(1);
    chk("rd_done_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rd_done_ready", 32'(bus.data_in_ready), 32'd1);

    // Write frame with cmd_ready held low for 10 cycles
    bus.cmd_ready = 1'b0;
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h04); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    send_byte(8'hEF);
    for (int i = 0; i < 10; i++) begin
      chk("wr_stall_valid", 32'(bus.cmd_valid), 32'd1);
      chk("wr_stall_ready", 32'(bus.data_in_ready), 32'd0);
      chk("wr_stall_write", 32'(bus.cmd_write), 32'd1);
      chk("wr_stall_addr", bus.cmd_addr, 32'h00001004);
      chk("wr_stall_wdata", bus.cmd_wdata, 32'hDEADBEEF);
      tick(1);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    chk("wr_done_valid", 32'(bus.cmd_valid), 32'd0);
    chk("wr_done_ready", 32'(bus.data_in_ready), 32'd1);

    // Bad command byte dropped, following read parses
    send_byte(8'h55);
    chk("bad_ferr", 32'(bus.frame_err), 32'd1);
    chk("bad_state_idle", 32'(bus.cmd_valid), 32'd0);
    send_byte(8'hA0);
    chk("bad_ferr_clear", 32'(bus.frame_err), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    chk("bad_rd_valid", 32'(bus.cmd_valid), 32'd1);
    chk("bad_rd_write", 32'(bus.cmd_write), 32'd0);
    chk("bad_rd_addr", bus.cmd_addr, 32'h00000008);
    tick(1);

    // Timeout in ADDR: 16 idle cycles abort
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00);
    tick(15);
    chk("to_no_abort_yet", 32'(bus.timeout_err), 32'd0);
    tick(1);
    chk("to_terr", 32'(bus.timeout_err), 32'd1);
    chk("to_valid", 32'(bus.cmd_valid), 32'd0);
    tick(1);
    chk("to_terr_clear", 32'(bus.timeout_err), 32'd0);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20);
    chk("to_rd_valid", 32'(bus.cmd_valid), 32'd1);
    chk("to_rd_write", 32'(bus.cmd_write), 32'd0);
    chk("to_rd_addr", bus.cmd_addr, 32'h00000020);
    tick(1);

    // Gap of TIMEOUT-1 idle cycles, byte on the would-expire cycle wins
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00);
    tick(15);
    send_byte(8'h00);
    chk("gap15_no_terr", 32'(bus.timeout_err), 32'd0);
    send_byte(8'h04);
    chk("gap15_valid", 32'(bus.cmd_valid), 32'd1);
    chk("gap15_addr", bus.cmd_addr, 32'h00000004);
    tick(1);

    // Gap of exactly TIMEOUT idle cycles inside DATA aborts
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h40); send_byte(8'hAB);
    tick(16);
    chk("gap16_terr", 32'(bus.timeout_err), 32'd1);
    chk("gap16_valid", 32'(bus.cmd_valid), 32'd0);
    chk("gap16_ready", 32'(bus.data_in_ready), 32'd1);
    tick(1);

    // Reset mid-frame
    send_byte(8'hA1); send_byte(8'h11); send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    chk("mrst_write", 32'(bus.cmd_write), 32'd0);
    chk("mrst_addr", bus.cmd_addr, 32'h0);
    chk("mrst_ready", 32'(bus.data_in_ready), 32'd1);
    chk("mrst_valid", 32'(bus.cmd_valid), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h0C); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04);
    chk("mrst_wr_valid", 32'(bus.cmd_valid), 32'd1);
    chk("mrst_wr_write", 32'(bus.cmd_write), 32'd1);
    chk("mrst_wr_addr", bus.cmd_addr, 32'h0000000C);
    chk("mrst_wr_wdata", bus.cmd_wdata, 32'h01020304);
    tick(2);

    // Overall error pulse counts
    chk("ferr_pulses", 32'(ferr_cnt), 32'd1);
    chk("terr_pulses", 32'(terr_cnt), 32'd2);
    chk("err_overlap", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart2apb_cmd_parser.md
Name: uart2apb_cmd_parser

Overview:
- Byte-stream command parser on the read side of the uart2apb byte prefetch FIFO.
- Consumes the FIFO's byte output over valid/ready and assembles framed read/write commands.
- Presents each command as one 32-bit APB request on a valid/ready interface to the APB master stage.
- Drops malformed frames and aborts stalled frames on an inter-byte timeout.

Parameters:
- TIMEOUT, 100000: idle cycles allowed between bytes of one frame before abort; 0 disables the timeout.
- TO_W, 17: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in_valid  in  1  byte available from prefetch FIFO
- data_in  in  8  byte from prefetch FIFO
- data_in_ready  out  1  parser accepts byte this cycle
- cmd_valid  out  1  assembled command valid
- cmd_ready  in  1  APB master accepts command
- cmd_write  out  1  1 = write, 0 = read
- cmd_addr  out  32  APB address
- cmd_wdata  out  32  write data; 0 for reads
- frame_err  out  1  one-cycle pulse: bad command byte dropped
- timeout_err  out  1  one-cycle pulse: frame aborted on timeout

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, data_in_ready=1, cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, frame_err=0, timeout_err=0, all counters 0.
- Frame format: CMD, then ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], then (write only) WDATA in the same MSB-first order. CMD 0xA1 = write, CMD 0xA0 = read.
- A byte is accepted when data_in_valid & data_in_ready.
- data_in_ready = (state != ISSUE).
- IDLE:
  - Accepted 0xA1: cmd_write<=1, cmd_wdata<=0, go ADDR.
  - Accepted 0xA0: cmd_write<=0, cmd_wdata<=0, go ADDR.
  - Any other accepted byte: discarded, frame_err pulses the next cycle, stay IDLE.
- ADDR: each accepted byte shifts into cmd_addr (cmd_addr <= {cmd_addr[23:0], byte}); a 2-bit byte counter increments. On the 4th byte the counter wraps to 0, and the state goes to DATA if cmd_write, else to ISSUE.
- DATA: same shifting into cmd_wdata; on the 4th byte go ISSUE.
- ISSUE:
  - cmd_valid=1.
  - cmd_write, cmd_addr and cmd_wdata are held stable until cmd_ready.
  - On cmd_valid & cmd_ready: cmd_valid<=0, go IDLE.
  - The next byte can be accepted in the following cycle.
- Latency: last frame byte accepted in cycle N -> cmd_valid=1 in cycle N+1. Minimum read frame = 5 byte cycles + 1 issue cycle.
- Timeout:
  - Counter is active only in ADDR/DATA. It clears on every accepted byte and on entry to IDLE/ISSUE.
  - When the counter reaches TIMEOUT-1 with no byte accepted: go IDLE, clear the byte counter, pulse timeout_err for one cycle.
  - cmd_addr/cmd_wdata are not cleared on abort; they are overwritten by the next frame.
  - Never active in IDLE or ISSUE. A stalled cmd_ready never times out.
- Simultaneous events: a byte accepted in the same cycle the counter would expire wins; the counter clears and there is no abort.
- Backpressure: in ISSUE the upstream FIFO holds data (ready low); no byte is lost or reordered.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost with no error pulse.
- frame_err and timeout_err are registered; they are never high in the same cycle.

Decomposition:
- Package uart2apb_pkg holds:
  - CMD_WR=8'hA1, CMD_RD=8'hA0
  - state encoding IDLE=2'd0, ADDR=2'd1, DATA=2'd2, ISSUE=2'd3
- Single module, no sub-module. The timeout counter is inline; it is too small to justify a separate block.

Test Plan:
- Read frame: bytes A0 12 34 56 78, cmd_ready=1 -> one cmd_valid cycle with cmd_write=0, cmd_addr=0x12345678, cmd_wdata=0, one cycle after byte 78 is accepted.
- Write frame: A1 00 00 10 04 DE AD BE EF with cmd_ready held low 10 cycles -> data_in_ready=0 and outputs stable for 10 cycles; then cmd_write=1, cmd_addr=0x00001004, cmd_wdata=0xDEADBEEF accepted once.
- Bad command: bytes 55 A0 00 00 00 08 -> frame_err pulses once; then a read command with cmd_addr=0x00000008.
- Timeout with TIMEOUT=16: A1 00 00, then a 16-cycle gap -> timeout_err pulses once, state IDLE; following frame A0 00 00 00 20 yields cmd_addr=0x00000020.
- Gap of TIMEOUT-1 cycles, then a byte: no abort, frame completes correctly. Gap of exactly TIMEOUT cycles: abort.
- Reset asserted after A1 11 22: all outputs return to reset values; the next valid frame parses correctly with no error pulse.
